// File: rtl/mod_step_counter.sv
// Parametrised up/down step counter with wrap/saturate boundary modes and parallel load.
// Latency: 1 cycle from sampled inputs to count/tc/boundary_flag; all outputs registered.
// Backpressure: none; every edge consumes the current inputs unconditionally.
module mod_step_counter #(
    parameter int unsigned     WIDTH   = 8,
    parameter longint unsigned MODULUS = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             up,
    input  logic [WIDTH-1:0] step,
    input  logic             sat_mode,
    input  logic             clr_flag,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             boundary_flag
);

    // One extra bit so MODULUS == 2**WIDTH and count+step are representable.
    localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_flag;

    logic [WIDTH:0]   w_cnt_x;
    logic [WIDTH:0]   w_step_x;
    logic [WIDTH:0]   w_sum;
    logic             w_step_zero;
    logic             w_step_bad;
    logic             w_load_ok;
    logic [WIDTH-1:0] w_nxt_count;
    logic             w_nxt_tc;

    assign w_cnt_x     = {1'b0, r_count};
    assign w_step_x    = {1'b0, step};
    assign w_sum       = w_cnt_x + w_step_x;
    assign w_step_zero = (step == '0);
    assign w_step_bad  = (w_step_x >= MOD_X);
    assign w_load_ok   = ({1'b0, load_value} < MOD_X);

    always_comb begin
        w_nxt_count = r_count;
        w_nxt_tc    = 1'b0;
        if (load) begin
            w_nxt_count = w_load_ok ? load_value : MAX_W;
        end else if (enable && !w_step_zero) begin
            if (up) begin
                if (sat_mode) begin
                    // Landing exactly on the top limit counts as a boundary hit.
                    if (w_sum >= MAX_X) begin
                        w_nxt_count = MAX_W;
                        w_nxt_tc    = 1'b1;
                    end else begin
                        w_nxt_count = w_sum[WIDTH-1:0];
                    end
                end else if (w_step_bad) begin
                    // Out-of-range step: pin to the limit rather than leave the range.
                    w_nxt_count = MAX_W;
                    w_nxt_tc    = 1'b1;
                end else if (w_sum >= MOD_X) begin
                    w_nxt_count = WIDTH'(w_sum - MOD_X);
                    w_nxt_tc    = 1'b1;
                end else begin
                    w_nxt_count = w_sum[WIDTH-1:0];
                end
            end else begin
                if (w_step_x < w_cnt_x) begin
                    w_nxt_count = WIDTH'(w_cnt_x - w_step_x);
                end else if (sat_mode || w_step_bad) begin
                    w_nxt_count = '0;
                    w_nxt_tc    = 1'b1;
                end else if (w_step_x == w_cnt_x) begin
                    // In wrap mode, arriving at zero is an ordinary value.
                    w_nxt_count = '0;
                end else begin
                    w_nxt_count = WIDTH'(w_cnt_x + MOD_X - w_step_x);
                    w_nxt_tc    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_flag  <= 1'b0;
        end else begin
            r_count <= w_nxt_count;
            r_tc    <= w_nxt_tc;
            r_flag  <= w_nxt_tc | (r_flag & ~clr_flag);
        end
    end

    assign count         = r_count;
    assign tc            = r_tc;
    assign boundary_flag = r_flag;

endmodule

// File: tb/tb_mod_step_counter.sv
// Bench for mod_step_counter: directed vector table on a WIDTH=4/MODULUS=10 instance,
// then randomized traffic on that and a WIDTH=8/MODULUS=256 instance against an arithmetic model.
module tb_mod_step_counter;

    typedef struct {
        bit rst, ld, en, up, sat, clr;
        int lv, st;
        int cnt, tc, flg;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset, a_enable, a_load, a_up, a_sat, a_clr;
    logic [3:0] a_lv, a_step, a_count;
    logic       a_tc, a_flag;

    logic       b_reset, b_enable, b_load, b_up, b_sat, b_clr;
    logic [7:0] b_lv, b_step, b_count;
    logic       b_tc, b_flag;

    mod_step_counter #(.WIDTH(4), .MODULUS(10)) u_a (
        .clk(clk), .reset(a_reset), .enable(a_enable), .load(a_load),
        .load_value(a_lv), .up(a_up), .step(a_step), .sat_mode(a_sat),
        .clr_flag(a_clr), .count(a_count), .tc(a_tc), .boundary_flag(a_flag)
    );

    mod_step_counter #(.WIDTH(8), .MODULUS(256)) u_b (
        .clk(clk), .reset(b_reset), .enable(b_enable), .load(b_load),
        .load_value(b_lv), .up(b_up), .step(b_step), .sat_mode(b_sat),
        .clr_flag(b_clr), .count(b_count), .tc(b_tc), .boundary_flag(b_flag)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic vec_t v(input bit rst, ld, en, up, sat, clr,
                               input int lv, st, cnt, tc, flg);
        vec_t r;
        r.rst = rst; r.ld = ld; r.en = en; r.up = up; r.sat = sat; r.clr = clr;
        r.lv = lv; r.st = st; r.cnt = cnt; r.tc = tc; r.flg = flg;
        return r;
    endfunction

    // Reference: plain integer arithmetic on the count value, modulus and step.
    function automatic void model(input int mod, input bit rst, ld, en, up, sat, clr,
                                  input int lv, st, inout int cnt, inout int flg,
                                  output int tc);
        int t;
        tc = 0;
        if (rst) begin
            cnt = 0;
            flg = 0;
            return;
        end
        if (ld) begin
            cnt = (lv < mod) ? lv : mod - 1;
        end else if (en && st != 0) begin
            if (up) begin
                t = cnt + st;
                if (sat) begin
                    if (t >= mod - 1) begin cnt = mod - 1; tc = 1; end
                    else cnt = t;
                end else if (t < mod) cnt = t;
                else begin cnt = t - mod; tc = 1; end
            end else begin
                t = cnt - st;
                if (t > 0) cnt = t;
                else if (sat) begin cnt = 0; tc = 1; end
                else if (t == 0) cnt = 0;
                else begin cnt = t + mod; tc = 1; end
            end
        end
        if (tc != 0) flg = 1;
        else if (clr) flg = 0;
    endfunction

    task automatic drive_a(input vec_t r);
        a_reset = r.rst; a_load = r.ld; a_enable = r.en; a_up = r.up;
        a_sat = r.sat; a_clr = r.clr; a_lv = 4'(r.lv); a_step = 4'(r.st);
    endtask

    function automatic int rnd_step(input int mod);
        case ($urandom_range(0, 3))
            0:       return $urandom_range(0, 2);
            1:       return $urandom_range(mod - 3, mod - 1);
            default: return $urandom_range(0, mod - 1);
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        int   ma_cnt, ma_flg, mb_cnt, mb_flg, tca, tcb;

        // Directed table, all on the MODULUS=10 instance.
        tbl.push_back(v(1,0,0,1,0,0, 0,0, 0,0,0));
        for (int i = 1; i <= 12; i++)
            tbl.push_back(v(0,0,1,1,0,0, 0,1, i % 10, (i == 10) ? 1 : 0, (i >= 10) ? 1 : 0));
        tbl.push_back(v(0,1,0,0,0,0, 4,0, 4,0,1));
        tbl.push_back(v(0,0,1,0,0,0, 0,3, 1,0,1));
        tbl.push_back(v(0,0,1,0,0,0, 0,3, 8,1,1));
        tbl.push_back(v(0,0,1,0,0,0, 0,3, 5,0,1));
        tbl.push_back(v(0,0,1,0,0,0, 0,3, 2,0,1));
        tbl.push_back(v(0,0,1,0,0,0, 0,3, 9,1,1));
        tbl.push_back(v(0,0,0,0,0,1, 0,0, 9,0,0));
        tbl.push_back(v(0,1,0,1,1,0, 3,0, 3,0,0));
        tbl.push_back(v(0,0,1,1,1,0, 0,4, 7,0,0));
        tbl.push_back(v(0,0,1,1,1,0, 0,4, 9,1,1));
        tbl.push_back(v(0,0,1,1,1,0, 0,4, 9,1,1));
        tbl.push_back(v(0,0,1,0,1,0, 0,5, 4,0,1));
        tbl.push_back(v(0,0,1,0,1,0, 0,5, 0,1,1));
        tbl.push_back(v(0,0,1,0,1,0, 0,0, 0,0,1));
        tbl.push_back(v(0,1,1,1,0,0, 13,1, 9,0,1));
        tbl.push_back(v(1,1,1,1,0,0, 13,1, 0,0,0));
        tbl.push_back(v(0,1,0,1,0,0, 9,0, 9,0,0));
        tbl.push_back(v(0,0,1,1,0,0, 0,2, 1,1,1));
        tbl.push_back(v(0,1,0,1,0,0, 8,0, 8,0,1));
        tbl.push_back(v(0,0,1,1,0,1, 0,3, 1,1,1));
        tbl.push_back(v(0,0,0,1,0,1, 0,0, 1,0,0));
        tbl.push_back(v(0,0,1,1,0,0, 0,0, 1,0,0));
        tbl.push_back(v(0,1,0,0,0,0, 3,0, 3,0,0));
        tbl.push_back(v(0,0,1,0,0,0, 0,3, 0,0,0));
        tbl.push_back(v(0,0,1,0,0,0, 0,1, 9,1,1));
        tbl.push_back(v(0,1,0,1,0,0, 5,0, 5,0,1));
        tbl.push_back(v(0,0,1,1,0,0, 0,4, 9,0,1));
        tbl.push_back(v(0,0,0,1,0,1, 0,0, 9,0,0));
        tbl.push_back(v(0,1,0,1,1,0, 5,0, 5,0,0));
        tbl.push_back(v(0,0,1,1,1,0, 0,4, 9,1,1));
        tbl.push_back(v(0,0,1,1,1,0, 0,0, 9,0,1));
        tbl.push_back(v(0,0,0,0,1,0, 0,3, 9,0,1));
        tbl.push_back(v(0,1,0,1,0,1, 2,0, 2,0,0));

        b_reset = 1'b1; b_load = 1'b0; b_enable = 1'b0; b_up = 1'b0;
        b_sat = 1'b0; b_clr = 1'b0; b_lv = '0; b_step = '0;

        foreach (tbl[i]) begin
            drive_a(tbl[i]);
            @(posedge clk); #1;
            chk($sformatf("row%0d.count", i), int'(a_count), tbl[i].cnt);
            chk($sformatf("row%0d.tc", i),    int'(a_tc),    tbl[i].tc);
            chk($sformatf("row%0d.flag", i),  int'(a_flag),  tbl[i].flg);
        end

        // Out-of-range steps must never leave the count outside 0..9.
        drive_a(v(0,1,0,1,0,0, 9,0, 0,0,0)); @(posedge clk); #1;
        drive_a(v(0,0,1,1,0,0, 0,15, 0,0,0)); @(posedge clk); #1;
        chk("illegal_up_wrap.range", int'(a_count < 4'd10), 1);
        drive_a(v(0,1,0,0,0,0, 2,0, 0,0,0)); @(posedge clk); #1;
        drive_a(v(0,0,1,0,0,0, 0,12, 0,0,0)); @(posedge clk); #1;
        chk("illegal_dn_wrap.range", int'(a_count < 4'd10), 1);
        drive_a(v(0,1,0,1,1,0, 2,0, 0,0,0)); @(posedge clk); #1;
        drive_a(v(0,0,1,1,1,0, 0,15, 0,0,0)); @(posedge clk); #1;
        chk("illegal_up_sat.count", int'(a_count), 9);
        chk("illegal_up_sat.tc", int'(a_tc), 1);

        // Random traffic on both instances, each against its own model.
        ma_cnt = 0; ma_flg = 0; mb_cnt = 0; mb_flg = 0;
        for (int c = 0; c < 10000; c++) begin
            vec_t ra, rb;
            ra = v((c == 0) || ($urandom_range(0, 299) == 0), $urandom_range(0, 15) == 0,
                   $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 7) == 0, $urandom_range(0, 15), rnd_step(10), 0, 0, 0);
            rb = v((c == 0) || ($urandom_range(0, 299) == 0), $urandom_range(0, 15) == 0,
                   $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 7) == 0, $urandom_range(0, 255), rnd_step(256), 0, 0, 0);
            drive_a(ra);
            b_reset = rb.rst; b_load = rb.ld; b_enable = rb.en; b_up = rb.up;
            b_sat = rb.sat; b_clr = rb.clr; b_lv = 8'(rb.lv); b_step = 8'(rb.st);
            model(10,  ra.rst, ra.ld, ra.en, ra.up, ra.sat, ra.clr, ra.lv, ra.st, ma_cnt, ma_flg, tca);
            model(256, rb.rst, rb.ld, rb.en, rb.up, rb.sat, rb.clr, rb.lv, rb.st, mb_cnt, mb_flg, tcb);
            @(posedge clk); #1;
            chk("rand_a.count", int'(a_count), ma_cnt);
            chk("rand_a.range", int'(a_count < 4'd10), 1);
            chk("rand_a.tc",    int'(a_tc),    tca);
            chk("rand_a.flag",  int'(a_flag),  ma_flg);
            chk("rand_b.count", int'(b_count), mb_cnt);
            chk("rand_b.tc",    int'(b_tc),    tcb);
            chk("rand_b.flag",  int'(b_flag),  mb_flg);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_step_counter.md
# mod_step_counter

Parametrised up/down counter: the successor of the team's fixed 4-bit up-counter. It adds configurable width and modulus, a per-cycle step size, and a direction select. It also has a wrap or saturate boundary mode, synchronous parallel load, a terminal-count pulse and a sticky boundary flag. It serves as the generic event, timer and address counter for datapath and control blocks.

## Interface
- WIDTH, 8, counter width in bits; legal range 2..32
- MODULUS, 256, count range is 0..MODULUS-1; legal range 2..2^WIDTH
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  reset, synchronous, active-high; clock clk
- enable  input  1  count-update qualifier
- load  input  1  synchronous parallel load
- load_value  input  WIDTH  value for load
- up  input  1  1 = count up, 0 = count down
- step  input  WIDTH  increment/decrement amount; legal 0..MODULUS-1
- sat_mode  input  1  0 = wrap modulo MODULUS, 1 = saturate at 0 / MODULUS-1
- clr_flag  input  1  clears boundary_flag
- count  output  WIDTH  current count (registered)
- tc  output  1  one-cycle pulse: the last update crossed or hit a boundary (registered)
- boundary_flag  output  1  sticky copy of tc (registered)

## Operation
- Priority per edge: reset > load > enable > hold.
- Reset: count=0, tc=0, boundary_flag=0.
- Load: count <= load_value if load_value < MODULUS, else MODULUS-1 (clamped). tc=0. Load does not touch boundary_flag except through clr_flag.
- Enable with up=1: compute sum = count + step in WIDTH+1 bits.
  - If sum < MODULUS: count <= sum, tc=0.
  - Wrap mode: count <= sum - MODULUS, tc=1.
  - Saturate mode: count <= MODULUS-1. tc=1 if sum >= MODULUS-1 and step != 0.
- Enable with up=0:
  - If step <= count and count-step > 0: count <= count-step, tc=0.
  - Wrap mode with step > count: count <= count + MODULUS - step, tc=1.
  - Saturate mode with step >= count: count <= 0. tc=1 if step != 0.
  - Wrap mode with count-step == 0: count <= 0, tc=0. Reaching 0 is not a boundary in wrap mode.
- Wrap mode, up: landing exactly on MODULUS-1 gives tc=0.
- Saturate mode: landing exactly on the limit gives tc=1. tc stays 1 on every enabled cycle while held at the limit with step != 0.
- step=0 with enable: count holds, tc=0.
- step >= MODULUS is illegal. The block must still not produce count >= MODULUS; it clamps per sat_mode as above.
- Enable low and no load: count holds, tc=0.
- boundary_flag <= 1 on any edge where tc is set to 1. Otherwise it clears on clr_flag. Set and clear in the same cycle: set wins.
- Changing up, sat_mode or step between cycles is legal. Each edge uses only the current-cycle inputs.

## Timing
- Latency 1 cycle: inputs sampled at edge N are visible on count/tc at edge N plus clock-to-q.
- tc is high for exactly one cycle per qualifying update. Back-to-back qualifying updates give tc high continuously.
- No combinational path from any input to any output.
- Reset asserted mid-count forces all outputs to 0 at the next edge, regardless of load/enable.
- Reset is synchronous only: outputs are undefined before the first edge with reset=1.

## Test plan
- WIDTH=4, MODULUS=10. Reset, then enable, up=1, step=1 for 12 cycles:
  - count goes 1..9, 0, 1, 2.
  - tc pulses only on the 9→0 edge.
  - boundary_flag goes 1 and stays.
- Same config, sat_mode=0, up=0, step=3, starting from load 4:
  - count goes 1, then 8 (tc=1), then 5, then 2, then 9 (tc=1).
- sat_mode=1, up=1, step=4, load 3:
  - count goes 7, then 9 (tc=1), then 9 (tc=1).
  - Switch up=0, step=5: count goes 4, then 0 (tc=1).
- load_value=13 with load=1 and enable=1 in the same cycle: count=9, tc=0. The same cycle with reset=1 gives count=0.
- clr_flag and a wrap event in the same cycle: boundary_flag stays 1. clr_flag alone on the next cycle clears it. step=0 with enable holds count with tc=0.
- Random up/step/sat_mode/load/enable for 10k cycles against a reference model:
  - count < MODULUS always.
  - tc and boundary_flag match the model every cycle.
  - Repeat with WIDTH=8, MODULUS=256.
